// File: rtl/aes_ks_pkg.sv
// Shared types and helpers for the word-serial AES key schedule.
package aes_ks_pkg;

    typedef logic [31:0] word_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int words_total(input int nk);
        return 4 * (nr_of(nk) + 1);
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four independent AES S-boxes applied byte-wise to one 32-bit word.
module aes_sub_word
    import aes_ks_pkg::*;
(
    input  word_t din,
    output word_t dout
);

    // Byte for input b sits at bits [2047-8b -: 8], i.e. index {~b, 3'b111}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign dout[8*g +: 8] = SBOX[{~din[8*g +: 8], 3'b111} -: 8];
    end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Word-serial AES key expansion: one schedule word per cycle through a single
// SubWord unit, packed into 128-bit round keys on a valid/ready port.
module aes_key_schedule_seq
    import aes_ks_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = nr_of(NK)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         done
);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_key_schedule_seq: NK must be 4, 6 or 8");
    end
    if (NR != nr_of(NK)) begin : g_bad_nr
        $error("aes_key_schedule_seq: NR must equal NK+6");
    end

    localparam logic [5:0] TOTAL_W  = 6'(words_total(NK));
    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [2:0] JMAX     = 3'(NK - 1);
    localparam logic [3:0] LAST_IDX = 4'(NR);

    word_t      win [NK];
    word_t      acc [3];
    logic [5:0] wcnt;
    logic [2:0] jcnt;
    logic [7:0] rcon;

    word_t prev, oldest, sub_in, sub_out, temp, new_word;
    logic  accept, hs, load_ok, step, last_word_of_rk;
    logic  unused_key_bits;

    assign unused_key_bits = ^key_in;

    assign accept          = start && !busy;
    assign hs              = rk_valid && rk_ready;
    assign load_ok         = !rk_valid || rk_ready;
    assign last_word_of_rk = (wcnt[1:0] == 2'd3);
    // Words 4r..4r+2 may run ahead; only the word completing a round key waits.
    assign step            = busy && (wcnt < TOTAL_W) && (!last_word_of_rk || load_ok);

    // Window keeps w[i-1] at index 0 and w[i-NK] at index NK-1. The key is
    // loaded reversed so that rotating it yields key words 0..NK-1 in order.
    assign prev   = win[0];
    assign oldest = win[NK-1];
    assign sub_in = (jcnt == 3'd0) ? {prev[7:0], prev[31:8]} : prev;

    aes_sub_word u_sub_word (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        temp = prev;
        if (jcnt == 3'd0) begin
            temp = sub_out ^ {24'h0, rcon};
        end else if (NK == 8 && jcnt == 3'd4) begin
            temp = sub_out;
        end
        new_word = (wcnt < NK_W) ? oldest : (oldest ^ temp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++)  acc[k] <= '0;
            wcnt <= '0;
            jcnt <= '0;
            rcon <= '0;
        end else if (accept) begin
            for (int k = 0; k < NK; k++) win[k] <= key_in[32*(NK-1-k) +: 32];
            wcnt <= '0;
            jcnt <= '0;
            rcon <= RCON_INIT;
        end else if (step) begin
            win[0] <= new_word;
            for (int k = 1; k < NK; k++) win[k] <= win[k-1];
            if (!last_word_of_rk) acc[wcnt[1:0]] <= new_word;
            wcnt <= wcnt + 6'd1;
            jcnt <= (jcnt == JMAX) ? 3'd0 : jcnt + 3'd1;
            if (jcnt == 3'd0 && wcnt >= NK_W) rcon <= xtime(rcon);
        end
    end

    // Output register: a new round key may replace one being handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            done     <= 1'b0;
        end else begin
            done <= hs && (rk_index == LAST_IDX);
            if (accept) begin
                busy <= 1'b1;
            end else if (hs && rk_index == LAST_IDX) begin
                busy <= 1'b0;
            end
            if (step && last_word_of_rk) begin
                rk_data  <= {new_word, acc[2], acc[1], acc[0]};
                rk_index <= wcnt[5:2];
                rk_valid <= 1'b1;
            end else if (hs) begin
                rk_valid <= 1'b0;
            end
        end
    end

endmodule
